// File: rtl/s_axil_register.sv
// s_axil_register
//   AXI4-Lite slave register file of NUM_REG words. AW and W are accepted
//   independently (either order, any gap), held, and committed together
//   under byte strobes; one write and one read may be in flight at once.
//
// Ports
//   ACLK                       clock, rising edge
//   ARESET                     synchronous reset, active low
//   AWADDR/AWVALID/AWREADY     write address channel
//   WDATA/WSTRB/WVALID/WREADY  write data channel
//   BRESP/BVALID/BREADY        write response channel
//   ARADDR/ARVALID/ARREADY     read address channel
//   RDATA/RRESP/RVALID/RREADY  read data channel
//
// Addresses at or above NUM_REG*4 answer SLVERR; reads of them return 0.
module s_axil_register #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REG          = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY
);

  localparam int STRB_W = S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REG);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                              en;
  logic                              aw_held;
  logic                              w_held;
  logic [S_AXI_ADDR_WIDTH-1:2]       awaddr_q;
  logic [S_AXI_DATA_WIDTH-1:0]       wdata_q;
  logic [STRB_W-1:0]                 wstrb_q;
  logic [S_AXI_DATA_WIDTH-1:0]       wmask;
  logic [S_AXI_DATA_WIDTH-1:0]       regs [NUM_REG];

  logic                              bvalid_q;
  logic [1:0]                        bresp_q;
  logic                              rvalid_q;
  logic [1:0]                        rresp_q;
  logic [S_AXI_DATA_WIDTH-1:0]       rdata_q;

  logic                              aw_hs;
  logic                              w_hs;
  logic                              ar_hs;
  logic                              commit;
  logic [IDX_W-1:0]                  wr_idx;
  logic [IDX_W-1:0]                  rd_idx;
  logic                              wr_in_range;
  logic                              rd_in_range;

  // Byte-offset address bits carry no meaning for a word register file.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  // Ready/valid outputs come straight from flops.
  assign AWREADY = en & ~aw_held;
  assign WREADY  = en & ~w_held;
  assign ARREADY = en & ~rvalid_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign commit = aw_held & w_held & ~bvalid_q;

  // In range iff every address bit above the index field is zero.
  assign wr_idx      = awaddr_q[IDX_W+1:2];
  assign wr_in_range = (awaddr_q[S_AXI_ADDR_WIDTH-1:IDX_W+2] == '0);
  assign rd_idx      = ARADDR[IDX_W+1:2];
  assign rd_in_range = (ARADDR[S_AXI_ADDR_WIDTH-1:IDX_W+2] == '0);

  for (genvar b = 0; b < STRB_W; b++) begin : g_wmask
    assign wmask[b*8 +: 8] = {8{wstrb_q[b]}};
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      en <= 1'b0;
    end else begin
      en <= 1'b1;
    end
  end

  // Write holding stage: a handshake can never coincide with commit on
  // the same channel because READY is low while the flag is set.
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= AWADDR[S_AXI_ADDR_WIDTH-1:2];
      end else if (commit) begin
        aw_held  <= 1'b0;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end else if (commit) begin
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      regs <= '{default: '0};
    end else if (commit && wr_in_range) begin
      regs[wr_idx] <= (regs[wr_idx] & ~wmask) | (wdata_q & wmask);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Nonblocking sampling of regs gives the pre-write value when a read
  // and a commit to the same register share an edge.
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_q  <= rd_in_range ? regs[rd_idx] : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s_axil_register.sv
// Directed bench for s_axil_register: inputs are driven and outputs sampled
// on the falling edge of ACLK; the DUT acts on the rising edge.
module tb_s_axil_register;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  s_axil_register #(
    .S_AXI_DATA_WIDTH(32),
    .S_AXI_ADDR_WIDTH(32),
    .NUM_REG(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .AWADDR(AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA(WDATA),
    .WSTRB(WSTRB),
    .WVALID(WVALID),
    .WREADY(WREADY),
    .BRESP(BRESP),
    .BVALID(BVALID),
    .BREADY(BREADY),
    .ARADDR(ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA(RDATA),
    .RRESP(RRESP),
    .RVALID(RVALID),
    .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs, got_b;
    int unsigned n;
    aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0; resp = 2'b11;
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = AWVALID & AWREADY;
      w_hs  = WVALID & WREADY;
      @(negedge ACLK);
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin WVALID  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("wr_accept", {aw_done, w_done}, 2'b11);
    BREADY = 1'b1;
    n = 0;
    while (!got_b && n < 50) begin
      if (BVALID) begin resp = BRESP; got_b = 1'b1; end
      @(negedge ACLK);
      n++;
    end
    BREADY = 1'b0;
    check("wr_bvalid_seen", got_b, 1'b1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    logic done, hs, got;
    int unsigned n;
    done = 1'b0; got = 1'b0; data = '1; resp = 2'b11;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      hs = ARVALID & ARREADY;
      @(negedge ACLK);
      if (hs) begin ARVALID = 1'b0; done = 1'b1; end
      n++;
    end
    ARVALID = 1'b0;
    check("rd_accept", done, 1'b1);
    n = 0;
    while (!got && n < 50) begin
      if (RVALID) begin data = RDATA; resp = RRESP; got = 1'b1; end
      @(negedge ACLK);
      n++;
    end
    RREADY = 1'b0;
    check("rd_rvalid_seen", got, 1'b1);
  endtask

  logic [1:0]  resp;
  logic [31:0] rdata;

  initial begin
    ARESET = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready",  WREADY,  1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid",  BVALID,  1'b0);
    check("rst_rvalid",  RVALID,  1'b0);
    check("rst_bresp",   BRESP,   2'b00);
    check("rst_rresp",   RRESP,   2'b00);
    check("rst_rdata",   RDATA,   32'h0);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("en_awready", AWREADY, 1'b1);
    check("en_wready",  WREADY,  1'b1);
    check("en_arready", ARREADY, 1'b1);

    // Write latency: AW and W at edge n, BVALID after n+1, B handshake at n+2
    AWADDR = 32'h4; AWVALID = 1'b1; WDATA = 32'h2; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    check("lat_awready_held", AWREADY, 1'b0);
    check("lat_wready_held",  WREADY,  1'b0);
    check("lat_bvalid_early", BVALID,  1'b0);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check("lat_bvalid",      BVALID,  1'b1);
    check("lat_bresp",       BRESP,   2'b00);
    check("lat_awready_rel", AWREADY, 1'b1);
    check("lat_wready_rel",  WREADY,  1'b1);
    BREADY = 1'b1;
    @(negedge ACLK);
    check("lat_bvalid_drop", BVALID, 1'b0);
    BREADY = 1'b0;

    // Read latency: AR at edge n, RVALID after n
    ARADDR = 32'h4; ARVALID = 1'b1;
    @(negedge ACLK);
    check("rlat_rvalid",  RVALID,  1'b1);
    check("rlat_rdata",   RDATA,   32'h2);
    check("rlat_rresp",   RRESP,   2'b00);
    check("rlat_arready", ARREADY, 1'b0);
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge ACLK);
    check("rlat_rvalid_drop", RVALID,  1'b0);
    check("rlat_arready_rel", ARREADY, 1'b1);
    RREADY = 1'b0;

    // Fill every register with index+1, then read back in order
    for (int i = 0; i < 16; i++) begin
      axi_write(32'(4 * i), 32'(i + 1), 4'hF, resp);
      check("fill_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 16; i++) begin
      axi_read(32'(4 * i), rdata, resp);
      check("fill_rresp", resp, 2'b00);
      check("fill_rdata", rdata, 32'(i + 1));
    end

    // Byte strobes
    axi_write(32'h08, 32'hAABBCCDD, 4'hF, resp);
    check("strb_full_bresp", resp, 2'b00);
    axi_write(32'h08, 32'h11223344, 4'b0101, resp);
    check("strb_part_bresp", resp, 2'b00);
    axi_read(32'h08, rdata, resp);
    check("strb_merge", rdata, 32'hAA22CC44);
    axi_write(32'h08, 32'hFFFFFFFF, 4'h0, resp);
    check("strb_zero_bresp", resp, 2'b00);
    axi_read(32'h08, rdata, resp);
    check("strb_zero_keep", rdata, 32'hAA22CC44);

    // Out-of-range accesses
    axi_write(32'h40, 32'hDEADBEEF, 4'hF, resp);
    check("oor_bresp", resp, 2'b10);
    axi_read(32'h40, rdata, resp);
    check("oor_rresp_40", resp, 2'b10);
    check("oor_rdata_40", rdata, 32'h0);
    axi_read(32'hFFFFFFFC, rdata, resp);
    check("oor_rresp_top", resp, 2'b10);
    check("oor_rdata_top", rdata, 32'h0);
    axi_read(32'h00, rdata, resp);
    check("oor_reg0_rresp", resp, 2'b00);
    check("oor_reg0_keep", rdata, 32'h1);

    // W three cycles ahead of AW
    WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    check("wfirst_wready_held", WREADY, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      check("wfirst_wready_held", WREADY, 1'b0);
      check("wfirst_no_bvalid", BVALID, 1'b0);
    end
    AWADDR = 32'h10; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("wfirst_no_bvalid_at_aw", BVALID, 1'b0);
    @(negedge ACLK);
    check("wfirst_bvalid", BVALID, 1'b1);
    check("wfirst_bresp", BRESP, 2'b00);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    axi_read(32'h10, rdata, resp);
    check("wfirst_rdata", rdata, 32'h55);

    // BREADY held low: second write held but not committed
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'h66; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check("bp_bvalid_first", BVALID, 1'b1);
    AWADDR = 32'h18; AWVALID = 1'b1; WDATA = 32'h77; WVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b0;
      check("bp_bvalid_stable", BVALID, 1'b1);
      check("bp_bresp_stable", BRESP, 2'b00);
      check("bp_awready_held", AWREADY, 1'b0);
      check("bp_wready_held", WREADY, 1'b0);
    end
    axi_read(32'h18, rdata, resp);
    check("bp_second_not_committed", rdata, 32'h7);
    check("bp_bvalid_after_read", BVALID, 1'b1);
    BREADY = 1'b1;
    @(negedge ACLK);
    check("bp_first_b_done", BVALID, 1'b0);
    @(negedge ACLK);
    check("bp_second_bvalid", BVALID, 1'b1);
    @(negedge ACLK);
    check("bp_second_b_done", BVALID, 1'b0);
    BREADY = 1'b0;
    axi_read(32'h14, rdata, resp);
    check("bp_first_rdata", rdata, 32'h66);
    axi_read(32'h18, rdata, resp);
    check("bp_second_rdata", rdata, 32'h77);

    // RREADY held low: RDATA stable, ARREADY low, pending AR ignored
    ARADDR = 32'h00; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    check("rbp_rvalid", RVALID, 1'b1);
    check("rbp_rdata", RDATA, 32'h1);
    check("rbp_arready", ARREADY, 1'b0);
    ARADDR = 32'h04;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check("rbp_rdata_stable", RDATA, 32'h1);
      check("rbp_rvalid_stable", RVALID, 1'b1);
      check("rbp_arready_low", ARREADY, 1'b0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    check("rbp_r_done", RVALID, 1'b0);
    check("rbp_arready_rel", ARREADY, 1'b1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("rbp_next_rvalid", RVALID, 1'b1);
    check("rbp_next_rdata", RDATA, 32'h2);
    @(negedge ACLK);
    check("rbp_next_done", RVALID, 1'b0);
    RREADY = 1'b0;

    // Same-edge AR and commit to 0x0C
    axi_write(32'h0C, 32'h7, 4'hF, resp);
    AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'h9; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h0C; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("coll_bvalid", BVALID, 1'b1);
    check("coll_rvalid", RVALID, 1'b1);
    check("coll_rdata_old", RDATA, 32'h7);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    axi_read(32'h0C, rdata, resp);
    check("coll_rdata_new", rdata, 32'h9);

    // Reset mid-operation with BVALID, aw_held and RVALID all set
    AWADDR = 32'h00; AWVALID = 1'b1; WDATA = 32'h1234; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    AWADDR = 32'h04; AWVALID = 1'b1;
    ARADDR = 32'h00; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; ARVALID = 1'b0;
    check("mrst_pre_bvalid", BVALID, 1'b1);
    check("mrst_pre_awheld", AWREADY, 1'b0);
    check("mrst_pre_rdata", RDATA, 32'h1234);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("mrst_awready", AWREADY, 1'b0);
    check("mrst_wready",  WREADY,  1'b0);
    check("mrst_arready", ARREADY, 1'b0);
    check("mrst_bvalid",  BVALID,  1'b0);
    check("mrst_rvalid",  RVALID,  1'b0);
    check("mrst_bresp",   BRESP,   2'b00);
    check("mrst_rdata",   RDATA,   32'h0);
    ARESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      check("mrst_no_bvalid", BVALID, 1'b0);
      check("mrst_no_rvalid", RVALID, 1'b0);
    end
    check("mrst_awready_rel", AWREADY, 1'b1);
    axi_read(32'h00, rdata, resp);
    check("mrst_reg0", rdata, 32'h0);
    check("mrst_reg0_rresp", resp, 2'b00);
    axi_read(32'h04, rdata, resp);
    check("mrst_reg1", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
